// File: rtl/dbus_pkg.sv
// Shared types and constants for the two-master register data bus arbiter.
// State encodings, default bus widths and one-hot grant values.
package dbus_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/dbus_if.sv
// Bundle of both master handshakes and the shared register-bank bus.
// slave = arbiter side, master = requesters plus register bank side.
interface dbus_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) ();

    logic                  M0_Req;
    logic                  M0_Wr;
    logic [ADDR_WIDTH-1:0] M0_Addr;
    logic [DATA_WIDTH-1:0] M0_Wdata;
    logic                  M0_Ack;
    logic [DATA_WIDTH-1:0] M0_Rdata;

    logic                  M1_Req;
    logic                  M1_Wr;
    logic [ADDR_WIDTH-1:0] M1_Addr;
    logic [DATA_WIDTH-1:0] M1_Wdata;
    logic                  M1_Ack;
    logic [DATA_WIDTH-1:0] M1_Rdata;

    logic [1:0]            Gnt;
    logic [ADDR_WIDTH-1:0] Addr;
    logic [DATA_WIDTH-1:0] Dout;
    logic [DATA_WIDTH-1:0] Din;
    logic                  Wr;

    modport slave (
        input  M0_Req, M0_Wr, M0_Addr, M0_Wdata,
        input  M1_Req, M1_Wr, M1_Addr, M1_Wdata,
        input  Din,
        output M0_Ack, M0_Rdata, M1_Ack, M1_Rdata,
        output Gnt, Addr, Dout, Wr
    );

    modport master (
        output M0_Req, M0_Wr, M0_Addr, M0_Wdata,
        output M1_Req, M1_Wr, M1_Addr, M1_Wdata,
        output Din,
        input  M0_Ack, M0_Rdata, M1_Ack, M1_Rdata,
        input  Gnt, Addr, Dout, Wr
    );

endinterface

// File: rtl/dbus_arb_sel.sv
// Combinational one-hot winner select for the two bus masters.
// DBUS_ARB_RR_EN: ptr breaks ties (1 = favour M1); else M0 always wins.
module dbus_arb_sel
    import dbus_pkg::*;
(
    input  logic [1:0] req,
`ifdef DBUS_ARB_RR_EN
    input  logic       ptr,
`endif
    output logic [1:0] win
);

    always_comb begin
        win = GNT_NONE;
        unique case (req)
            2'b01: win = GNT_M0;
            2'b10: win = GNT_M1;
`ifdef DBUS_ARB_RR_EN
            2'b11: win = ptr ? GNT_M1 : GNT_M0;
`else
            2'b11: win = GNT_M0;
`endif
            default: win = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master arbiter/sequencer for the 8-bit register data bus.
// DBUS_ARB_RR_EN selects round-robin ties; default is fixed M0 priority.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic  Clk,
    input  logic  Rst_n,
    dbus_if.slave bus
);

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            win;
    logic [1:0]            gnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  wr_q;
    logic [1:0]            ack_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

`ifdef DBUS_ARB_RR_EN
    logic ptr_q;

    dbus_arb_sel u_sel (
        .req ({bus.M1_Req, bus.M0_Req}),
        .ptr (ptr_q),
        .win (win)
    );

    // Favour whichever master was not granted last.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr_q <= 1'b0;
        end else if (state_q == IDLE && win != GNT_NONE) begin
            ptr_q <= win[0];
        end
    end
`else
    dbus_arb_sel u_sel (
        .req ({bus.M1_Req, bus.M0_Req}),
        .win (win)
    );
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (win != GNT_NONE) state_d = XFER;
            XFER: state_d = ACK;
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            gnt_q    <= GNT_NONE;
            addr_q   <= '0;
            dout_q   <= '0;
            wr_q     <= 1'b0;
            ack_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win != GNT_NONE) begin
                        gnt_q  <= win;
                        addr_q <= win[1] ? bus.M1_Addr : bus.M0_Addr;
                        dout_q <= win[1] ? bus.M1_Wdata : bus.M0_Wdata;
                        wr_q   <= win[1] ? bus.M1_Wr : bus.M0_Wr;
                    end
                end
                XFER: begin
                    // Slave commits the write on this edge; reads land here.
                    wr_q  <= 1'b0;
                    ack_q <= gnt_q;
                    if (!wr_q) begin
                        if (gnt_q[1]) rdata1_q <= bus.Din;
                        else          rdata0_q <= bus.Din;
                    end
                end
                ACK: begin
                    ack_q <= 2'b00;
                    gnt_q <= GNT_NONE;
                end
                default: begin
                    ack_q <= 2'b00;
                end
            endcase
        end
    end

    assign bus.Gnt      = gnt_q;
    assign bus.Addr     = addr_q;
    assign bus.Dout     = dout_q;
    assign bus.Wr       = wr_q;
    assign bus.M0_Ack   = ack_q[0];
    assign bus.M1_Ack   = ack_q[1];
    assign bus.M0_Rdata = rdata0_q;
    assign bus.M1_Rdata = rdata1_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: vector table, directed corner cases, random traffic.
// Honours DBUS_ARB_RR_EN for the expected arbitration order.
module tb_dbus_arbiter;

`ifdef DBUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic       m;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd0;
        logic [7:0] rd1;
    } vec_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    dbus_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    dbus_arbiter dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    logic       m_req   [2];
    logic       m_wr    [2];
    logic [7:0] m_addr  [2];
    logic [7:0] m_wdata [2];
    logic [7:0] bank    [256];

    assign bus.M0_Req   = m_req[0];
    assign bus.M0_Wr    = m_wr[0];
    assign bus.M0_Addr  = m_addr[0];
    assign bus.M0_Wdata = m_wdata[0];
    assign bus.M1_Req   = m_req[1];
    assign bus.M1_Wr    = m_wr[1];
    assign bus.M1_Addr  = m_addr[1];
    assign bus.M1_Wdata = m_wdata[1];
    assign bus.Din      = bank[bus.Addr];

    always @(posedge Clk) if (bus.Wr) bank[bus.Addr] <= bus.Dout;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Rst_n = 1'b0;
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        repeat (2) tick();
        chk("rst_gnt", 8'(bus.Gnt), 8'h00);
        chk("rst_wr", 8'(bus.Wr), 8'h00);
        chk("rst_addr", bus.Addr, 8'h00);
        chk("rst_dout", bus.Dout, 8'h00);
        chk("rst_ack", 8'({bus.M1_Ack, bus.M0_Ack}), 8'h00);
        chk("rst_rd0", bus.M0_Rdata, 8'h00);
        chk("rst_rd1", bus.M1_Rdata, 8'h00);
        Rst_n = 1'b1;
    endtask

    task automatic single_txn(input vec_t v);
        m_req[v.m]   = 1'b1;
        m_wr[v.m]    = v.wr;
        m_addr[v.m]  = v.addr;
        m_wdata[v.m] = v.wdata;
        tick();
        chk("t_gnt", 8'(bus.Gnt), v.m ? 8'd2 : 8'd1);
        chk("t_wr", 8'(bus.Wr), 8'(v.wr));
        chk("t_addr", bus.Addr, v.addr);
        chk("t_dout", bus.Dout, v.wdata);
        tick();
        chk("t_wr_off", 8'(bus.Wr), 8'h00);
        chk("t_ack", 8'({bus.M1_Ack, bus.M0_Ack}), v.m ? 8'd2 : 8'd1);
        chk("t_rd0", bus.M0_Rdata, v.rd0);
        chk("t_rd1", bus.M1_Rdata, v.rd1);
        tick();
        m_req[v.m] = 1'b0;
        chk("t_ack_off", 8'({bus.M1_Ack, bus.M0_Ack}), 8'h00);
        chk("t_gnt_off", 8'(bus.Gnt), 8'h00);
        tick();
        chk("t_idle", 8'(bus.Gnt), 8'h00);
    endtask

    // Reference model state for random traffic
    int         phase;
    int         cur;
    int         last_win;
    logic       cur_wr;
    logic [7:0] cur_addr;
    logic [7:0] mem [256];
    logic [1:0] e_gnt;
    logic       e_wr;
    logic [7:0] e_addr;
    logic [7:0] e_dout;
    logic [1:0] e_ack;
    logic [7:0] e_rd [2];
    logic       done [2];

    task automatic model_step();
        int w;
        unique case (phase)
            0: begin
                if (m_req[0] || m_req[1]) begin
                    if (m_req[0] && m_req[1]) w = (RR && last_win == 0) ? 1 : 0;
                    else w = m_req[1] ? 1 : 0;
                    cur = w;
                    last_win = w;
                    cur_wr = m_wr[w];
                    cur_addr = m_addr[w];
                    e_gnt = (w == 1) ? 2'b10 : 2'b01;
                    e_wr = m_wr[w];
                    e_addr = m_addr[w];
                    e_dout = m_wdata[w];
                    phase = 1;
                end
            end
            1: begin
                if (cur_wr) mem[cur_addr] = e_dout;
                else e_rd[cur] = mem[cur_addr];
                e_wr = 1'b0;
                e_ack = (cur == 1) ? 2'b10 : 2'b01;
                phase = 2;
            end
            default: begin
                e_ack = 2'b00;
                e_gnt = 2'b00;
                phase = 0;
            end
        endcase
    endtask

    task automatic new_req(input int m);
        m_req[m]   = 1'b1;
        m_wr[m]    = 1'($urandom_range(1, 0));
        m_addr[m]  = 8'h20 + 8'($urandom_range(31, 0));
        m_wdata[m] = 8'($urandom);
    endtask

    vec_t       tbl [8];
    logic [1:0] gq  [4];
    int         gc  [4];

    initial begin
        logic [1:0] prev;
        logic [7:0] pat;
        int n;

        for (int i = 0; i < 256; i++) begin
            bank[i] = 8'h00;
            mem[i]  = 8'h00;
        end
        for (int m = 0; m < 2; m++) begin
            m_req[m] = 1'b0;
            m_wr[m] = 1'b0;
            m_addr[m] = 8'h00;
            m_wdata[m] = 8'h00;
        end

        tbl[0] = '{1'b0, 1'b1, 8'h04, 8'hA5, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h10, 8'h3C, 8'h00, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 8'h10, 8'h99, 8'h00, 8'h3C};
        tbl[3] = '{1'b0, 1'b0, 8'h04, 8'h00, 8'hA5, 8'h3C};
        tbl[4] = '{1'b1, 1'b1, 8'hFF, 8'h5A, 8'hA5, 8'h3C};
        tbl[5] = '{1'b1, 1'b0, 8'hFF, 8'h12, 8'hA5, 8'h5A};
        tbl[6] = '{1'b0, 1'b0, 8'h10, 8'h34, 8'h3C, 8'h5A};
        tbl[7] = '{1'b1, 1'b0, 8'h04, 8'h56, 8'h3C, 8'hA5};

        // Random traffic on 0x20..0x3F against the reference model
        apply_reset();
        phase = 0;
        cur = 0;
        last_win = 1;
        cur_wr = 1'b0;
        cur_addr = 8'h00;
        e_gnt = 2'b00;
        e_wr = 1'b0;
        e_addr = 8'h00;
        e_dout = 8'h00;
        e_ack = 2'b00;
        e_rd[0] = 8'h00;
        e_rd[1] = 8'h00;
        done[0] = 1'b0;
        done[1] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge Clk);
            model_step();
            #1;
            chk("r_gnt", 8'(bus.Gnt), 8'(e_gnt));
            chk("r_wr", 8'(bus.Wr), 8'(e_wr));
            chk("r_addr", bus.Addr, e_addr);
            chk("r_dout", bus.Dout, e_dout);
            chk("r_ack", 8'({bus.M1_Ack, bus.M0_Ack}), 8'(e_ack));
            chk("r_rd0", bus.M0_Rdata, e_rd[0]);
            chk("r_rd1", bus.M1_Rdata, e_rd[1]);
            for (int m = 0; m < 2; m++) begin
                if (done[m]) begin
                    done[m] = 1'b0;
                    if ($urandom_range(1, 0) == 1) new_req(m);
                    else m_req[m] = 1'b0;
                end else if (!m_req[m] && $urandom_range(2, 0) == 0) begin
                    new_req(m);
                end
                if (e_ack[m]) done[m] = 1'b1;
            end
        end
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        repeat (4) tick();

        // Vector table of single transactions
        apply_reset();
        for (int i = 0; i < 8; i++) single_txn(tbl[i]);

        // Simultaneous requests held for four transactions
        apply_reset();
        m_wr[0] = 1'b0;
        m_wr[1] = 1'b0;
        m_addr[0] = 8'h20;
        m_addr[1] = 8'h21;
        m_req[0] = 1'b1;
        m_req[1] = 1'b1;
        prev = 2'b00;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.Gnt != 2'b00 && prev == 2'b00) begin
                if (n < 4) begin
                    gq[n] = bus.Gnt;
                    gc[n] = c;
                end
                n++;
            end
            prev = bus.Gnt;
        end
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        chk("sim_count", 8'(n), 8'd4);
        for (int i = 0; i < 4 && i < n; i++) begin
            chk("sim_order", 8'(gq[i]), (RR && i % 2 == 1) ? 8'd2 : 8'd1);
            if (i > 0) chk("sim_space", 8'(gc[i] - gc[i-1]), 8'd3);
        end
        repeat (3) tick();

        // Late arrival: M1 requests during M0's XFER
        apply_reset();
        m_wr[0] = 1'b1;
        m_addr[0] = 8'h30;
        m_wdata[0] = 8'h77;
        m_req[0] = 1'b1;
        tick();
        chk("late_gnt0", 8'(bus.Gnt), 8'd1);
        m_wr[1] = 1'b0;
        m_addr[1] = 8'h30;
        m_wdata[1] = 8'hEE;
        m_req[1] = 1'b1;
        tick();
        chk("late_ack0", 8'({bus.M1_Ack, bus.M0_Ack}), 8'd1);
        chk("late_addr0", bus.Addr, 8'h30);
        tick();
        m_req[0] = 1'b0;
        chk("late_gap", 8'(bus.Gnt), 8'd0);
        tick();
        chk("late_gnt1", 8'(bus.Gnt), 8'd2);
        chk("late_wr1", 8'(bus.Wr), 8'd0);
        tick();
        chk("late_ack1", 8'({bus.M1_Ack, bus.M0_Ack}), 8'd2);
        chk("late_rd1", bus.M1_Rdata, 8'h77);
        chk("late_rd0", bus.M0_Rdata, 8'h00);
        tick();
        m_req[1] = 1'b0;
        repeat (2) tick();

        // Reset in the XFER cycle of a write
        apply_reset();
        single_txn('{1'b0, 1'b1, 8'h08, 8'h11, 8'h00, 8'h00});
        m_wr[0] = 1'b1;
        m_addr[0] = 8'h08;
        m_wdata[0] = 8'hFF;
        m_req[0] = 1'b1;
        tick();
        chk("rmid_wr", 8'(bus.Wr), 8'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rmid_wr0", 8'(bus.Wr), 8'd0);
        chk("rmid_gnt0", 8'(bus.Gnt), 8'd0);
        chk("rmid_ack0", 8'({bus.M1_Ack, bus.M0_Ack}), 8'd0);
        chk("rmid_addr0", bus.Addr, 8'h00);
        m_req[0] = 1'b0;
        tick();
        Rst_n = 1'b1;
        chk("rmid_reg08", bank[8], 8'h11);
        tick();
        single_txn('{1'b0, 1'b0, 8'h08, 8'h00, 8'h11, 8'h00});

        // Back-to-back from a single master
        apply_reset();
        m_wr[0] = 1'b0;
        m_addr[0] = 8'h20;
        m_req[0] = 1'b1;
        pat = 8'h00;
        for (int c = 0; c < 8; c++) begin
            tick();
            pat[c] = bus.M0_Ack;
        end
        m_req[0] = 1'b0;
        chk("b2b_ack_pat", pat, 8'b1001_0010);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter and sequencer for the 8-bit register data bus. Accepts write or read requests from two independent masters, selects one per transaction, and drives the shared bus signals (Addr, Dout, Wr) to the register bank. It captures the bank's read data from Din and returns it with a one-cycle acknowledge. It sits between the CPU-side and test/DMA-side masters and the single register-bank slave.

## Interface
- DATA_WIDTH, 8, bus data width
- ADDR_WIDTH, 8, bus address width
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  system reset, asynchronous, active low
- M0_Req  in  1  master 0 transaction request, level
- M0_Wr  in  1  master 0 direction, 1 = write, 0 = read
- M0_Addr  in  ADDR_WIDTH  master 0 register address
- M0_Wdata  in  DATA_WIDTH  master 0 write data
- M0_Ack  out  1  master 0 completion pulse
- M0_Rdata  out  DATA_WIDTH  master 0 read data, valid while M0_Ack = 1
- M1_Req, M1_Wr, M1_Addr, M1_Wdata, M1_Ack, M1_Rdata  same as M0, for master 1
- Gnt  out  2  one-hot grant; bit n = master n owns the bus
- Addr  out  ADDR_WIDTH  bus address to slave
- Dout  out  DATA_WIDTH  bus write data to slave
- Din  in  DATA_WIDTH  bus read data from slave, combinational from Addr
- Wr  out  1  bus write enable; slave writes on the Clk edge where Wr = 1

## Operation
- FSM has three states: IDLE, XFER, ACK.
- IDLE:
  - If no request is present, stay in IDLE.
  - If any Req = 1, select a winner, register its Addr/Wdata onto Addr/Dout, set Wr to the winner's Wr, set its Gnt bit, and go to XFER.
- XFER: lasts one cycle.
  - The bus is stable and the slave commits a write at the closing edge.
  - At that edge: Wr <= 0; the winner's Rdata <= Din (read only, Rdata unchanged on write); the winner's Ack <= 1; go to ACK.
- ACK: lasts one cycle.
  - Ack <= 0 and Gnt <= 0; go to IDLE.
- Handshake:
  - A master holds Req, Wr, Addr and Wdata stable from assertion until it samples Ack = 1.
  - It deasserts Req at that same edge.
  - A Req still high in IDLE is a new transaction.
- Arbitration applies only in IDLE; a request arriving during XFER or ACK waits.
- Addr and Dout hold their last values after a transaction; they do not return to zero.
- Rdata holds its last captured value until the next read for that master.
- Only one Ack is high at a time; Gnt is never 2'b11.

## Timing
- Reset values: Addr = 0, Dout = 0, Wr = 0, Gnt = 0, M0_Ack = M1_Ack = 0, M0_Rdata = M1_Rdata = 0, state = IDLE, round-robin pointer = favour M0.
- Latency: Req sampled high at edge k -> Wr/Addr valid after k -> slave write at edge k+1 -> Ack high from k+1 to k+2.
- Throughput: one transaction per 3 cycles under back-to-back requests.
- Reset mid-transaction: asynchronous. All outputs go to their reset values immediately and the transaction is dropped; a write not yet at its commit edge does not occur.
- Wr is high for exactly one cycle per write, never for reads.

## Configuration
- DBUS_ARB_RR_EN defined: round-robin arbitration.
  - When both masters request in IDLE, the master not granted last wins.
  - The pointer updates on each grant.
- DBUS_ARB_RR_EN undefined: fixed priority; M0 always wins simultaneous requests and M1 can starve. The pointer register is not built.

## Structure
- Package dbus_pkg holds:
  - state encodings IDLE = 2'd0, XFER = 2'd1, ACK = 2'd2
  - default DATA_WIDTH / ADDR_WIDTH constants
  - the one-hot grant constants GNT_M0 = 2'b01, GNT_M1 = 2'b10
- One sub-module, dbus_arb_sel: combinational winner select from {M1_Req, M0_Req} and the pointer, producing a one-hot winner. It contains the DBUS_ARB_RR_EN selection.
- FSM, bus registers and Rdata/Ack registers live in dbus_arbiter.

## Test plan
- Single write: M0 write Addr = 8'h04, Wdata = 8'hA5 -> Wr high exactly 1 cycle with Addr = 04, Dout = A5; M0_Ack pulses on the following cycle; register 04 reads A5.
- Single read: preload reg 8'h10 = 8'h3C; M1 read 8'h10 -> Wr stays 0; M1_Ack 1 cycle with M1_Rdata = 3C; M0_Rdata unchanged.
- Simultaneous requests, DBUS_ARB_RR_EN defined: both masters hold Req for 4 transactions -> grants alternate M0, M1, M0, M1 with 3-cycle spacing. Without the macro: M0, M0, M0, M0.
- Late arrival: M1 raises Req during M0's XFER -> M1 is granted in the next IDLE, with no corruption of M0's transaction.
- Reset mid-op: Rst_n low during XFER of a write 8'h08 <= 8'hFF -> Wr, Gnt, Ack go 0 immediately; reg 08 is unchanged; after release, a new request completes normally.
- Back-to-back single master: M0 holds Req through Ack -> second transaction starts in the IDLE cycle after ACK; Ack pulses are separated by 2 low cycles.
